// File: rtl/ctrl_pkg.sv
// Shared constants, state encoding and opcode predicates for the multi-cycle control FSM.
package ctrl_pkg;

  localparam int OP_W = 4;

  localparam logic [3:0] OP_LW       = 4'b0000;
  localparam logic [3:0] OP_SW       = 4'b0001;
  localparam logic [3:0] OP_RTYPE_LO = 4'b0010;
  localparam logic [3:0] OP_RTYPE_HI = 4'b1001;
  localparam logic [3:0] OP_BEQ      = 4'b1011;
  localparam logic [3:0] OP_BNE      = 4'b1100;
  localparam logic [3:0] OP_J        = 4'b1101;

  localparam logic [1:0] ALUOP_ADD  = 2'b10;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b00;

  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_ADDR   = 4'd2,
    S_MEM_RD = 4'd3,
    S_MEM_WR = 4'd4,
    S_WB_MEM = 4'd5,
    S_EXEC   = 4'd6,
    S_WB_ALU = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_TRAP   = 4'd10
  } state_t;

  function automatic logic is_rtype(input logic [OP_W-1:0] op);
    return (op >= OP_RTYPE_LO) && (op <= OP_RTYPE_HI);
  endfunction

  function automatic logic is_mem(input logic [OP_W-1:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic is_branch(input logic [OP_W-1:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational datapath-enable decode from the current state; all enables are forced low during reset.
module ctrl_out_decode
  import ctrl_pkg::*;
(
  input  state_t          state,
  input  logic [OP_W-1:0] op_q,
  input  logic            zero,
  input  logic            mem_ready,
  input  logic            rst,
  output logic [1:0]      ALUOp,
  output logic            alu_src,
  output logic            mem_read,
  output logic            mem_write,
  output logic            i_or_d,
  output logic            ir_write,
  output logic            pc_write,
  output logic [1:0]      pc_src,
  output logic            reg_write,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            instr_done
);

  always_comb begin
    ALUOp      = ALUOP_FUNC;
    alu_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PCSRC_SEQ;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    instr_done = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          ALUOp    = ALUOP_ADD;
          mem_read = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
          pc_src   = PCSRC_SEQ;
        end
        S_ADDR: begin
          ALUOp   = ALUOP_ADD;
          alu_src = 1'b1;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WR: begin
          mem_write  = 1'b1;
          i_or_d     = 1'b1;
          instr_done = mem_ready;
        end
        S_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        S_EXEC: begin
          ALUOp   = ALUOP_FUNC;
          alu_src = 1'b0;
        end
        S_WB_ALU: begin
          ALUOp      = ALUOP_FUNC;
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
        end
        // Taken decision uses the opcode latched in DECODE, never the live IR field.
        S_BRANCH: begin
          ALUOp      = ALUOP_SUB;
          alu_src    = 1'b0;
          pc_src     = PCSRC_BRANCH;
          pc_write   = ((op_q == OP_BEQ) && zero) || ((op_q == OP_BNE) && !zero);
          instr_done = 1'b1;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_src     = PCSRC_JUMP;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle main control FSM: state register, latched opcode, sticky trap flag and next-state logic.
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter int IR_OP_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IR_OP_W-1:0] Opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic [1:0]         ALUOp,
  output logic               alu_src,
  output logic               mem_read,
  output logic               mem_write,
  output logic               i_or_d,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               instr_done,
  output logic               illegal
);

  state_t             state;
  state_t             state_next;
  logic [IR_OP_W-1:0] op_q;
  logic               illegal_q;

  // DECODE dispatches on the live opcode because op_q is only loaded at the end of that cycle.
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        if (is_mem(Opcode))         state_next = S_ADDR;
        else if (is_rtype(Opcode))  state_next = S_EXEC;
        else if (is_branch(Opcode)) state_next = S_BRANCH;
        else if (Opcode == OP_J)    state_next = S_JUMP;
        else                        state_next = S_TRAP;
      end
      S_ADDR:   state_next = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: if (mem_ready) state_next = S_WB_MEM;
      S_MEM_WR: if (mem_ready) state_next = S_FETCH;
      S_WB_MEM: state_next = S_FETCH;
      S_EXEC:   state_next = S_WB_ALU;
      S_WB_ALU: state_next = S_FETCH;
      S_BRANCH: state_next = S_FETCH;
      S_JUMP:   state_next = S_FETCH;
      S_TRAP:   state_next = S_TRAP;
      default:  state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_DECODE) op_q <= Opcode;
      if (state_next == S_TRAP) illegal_q <= 1'b1;
    end
  end

  assign illegal = illegal_q & ~rst;

  ctrl_out_decode u_decode (
    .state      (state),
    .op_q       (op_q),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .rst        (rst),
    .ALUOp      (ALUOp),
    .alu_src    (alu_src),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .i_or_d     (i_or_d),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .instr_done (instr_done)
  );

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: each instruction is expanded into a per-cycle plan of inputs and expected outputs.
module tb_multicycle_control_unit;

  logic       clk;
  logic       rst;
  logic [3:0] Opcode;
  logic       zero;
  logic       mem_ready;
  logic [1:0] ALUOp;
  logic       alu_src, mem_read, mem_write, i_or_d, ir_write, pc_write;
  logic [1:0] pc_src;
  logic       reg_write, reg_dst, mem_to_reg, instr_done, illegal;

  int checks = 0;
  int errors = 0;

  logic [14:0] exp_q[$];
  string       tag_q[$];

  logic        plan_mr[$];
  logic [3:0]  plan_op[$];
  logic        plan_z[$];
  logic [14:0] plan_exp[$];
  string       plan_tag[$];

  multicycle_control_unit #(.IR_OP_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .Opcode     (Opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .ALUOp      (ALUOp),
    .alu_src    (alu_src),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .i_or_d     (i_or_d),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .instr_done (instr_done),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] vec(input logic [1:0] aluop, input logic src, input logic mrd,
                                      input logic mwr, input logic iord, input logic irw,
                                      input logic pcw, input logic [1:0] pcs, input logic rw,
                                      input logic rdst, input logic m2r, input logic done,
                                      input logic ill);
    return {aluop, src, mrd, mwr, iord, irw, pcw, pcs, rw, rdst, m2r, done, ill};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] rop();
    return 4'($urandom_range(0, 15));
  endfunction

  task automatic checkOutput(input logic [14:0] expv, input string tag);
    logic [14:0] act;
    act = {ALUOp, alu_src, mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src,
           reg_write, reg_dst, mem_to_reg, instr_done, illegal};
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", tag, act, expv);
    end
  endtask

  // Monitor: the DUT presents a control word every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) checkOutput(exp_q.pop_front(), tag_q.pop_front());
  end

  task automatic applyStimulus(input logic r_in, input logic mr, input logic [3:0] op,
                               input logic z, input logic [14:0] e, input string tag);
    rst       = r_in;
    mem_ready = mr;
    Opcode    = op;
    zero      = z;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic plan(input logic mr, input logic [3:0] op, input logic z,
                      input logic [14:0] e, input string tag);
    plan_mr.push_back(mr);
    plan_op.push_back(op);
    plan_z.push_back(z);
    plan_exp.push_back(e);
    plan_tag.push_back(tag);
  endtask

  // Reference model: expands one instruction into its cycle sequence from the opcode map.
  task automatic build_instr(input logic [3:0] op, input int fw, input int dw,
                             input logic z, input int trap_len);
    logic taken;
    for (int i = 0; i < fw; i++)
      plan(1'b0, rop(), rbit(), vec(2'b10,0,1,0,0,0,0,2'b00,0,0,0,0,0), "fetch_wait");
    plan(1'b1, rop(), rbit(), vec(2'b10,0,1,0,0,1,1,2'b00,0,0,0,0,0), "fetch_ready");
    plan(rbit(), op, rbit(), '0, "decode");
    if (op == 4'd0 || op == 4'd1) begin
      plan(rbit(), rop(), rbit(), vec(2'b10,1,0,0,0,0,0,2'b00,0,0,0,0,0), "addr");
      if (op == 4'd0) begin
        for (int i = 0; i < dw; i++)
          plan(1'b0, rop(), rbit(), vec(2'b00,0,1,0,1,0,0,2'b00,0,0,0,0,0), "memrd_wait");
        plan(1'b1, rop(), rbit(), vec(2'b00,0,1,0,1,0,0,2'b00,0,0,0,0,0), "memrd_ready");
        plan(rbit(), rop(), rbit(), vec(2'b00,0,0,0,0,0,0,2'b00,1,0,1,1,0), "wb_mem");
      end else begin
        for (int i = 0; i < dw; i++)
          plan(1'b0, rop(), rbit(), vec(2'b00,0,0,1,1,0,0,2'b00,0,0,0,0,0), "memwr_wait");
        plan(1'b1, rop(), rbit(), vec(2'b00,0,0,1,1,0,0,2'b00,0,0,0,1,0), "memwr_ready");
      end
    end else if (op >= 4'd2 && op <= 4'd9) begin
      plan(rbit(), rop(), rbit(), '0, "exec");
      plan(rbit(), rop(), rbit(), vec(2'b00,0,0,0,0,0,0,2'b00,1,1,0,1,0), "wb_alu");
    end else if (op == 4'd11 || op == 4'd12) begin
      taken = (op == 4'd11) ? z : !z;
      plan(rbit(), rop(), z, vec(2'b01,0,0,0,0,0,taken,2'b01,0,0,0,1,0), "branch");
    end else if (op == 4'd13) begin
      plan(rbit(), rop(), rbit(), vec(2'b00,0,0,0,0,0,1,2'b10,0,0,0,1,0), "jump");
    end else begin
      for (int i = 0; i < trap_len; i++)
        plan(rbit(), rop(), rbit(), vec(2'b00,0,0,0,0,0,0,2'b00,0,0,0,0,1), "trap");
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, rbit(), rop(), rbit(), '0, "reset");
  endtask

  // Plays the plan; abort_at >= 0 replaces that cycle onward with a reset pulse.
  task automatic play(input int abort_at);
    int  n;
    bit  aborted;
    n = plan_mr.size();
    aborted = 0;
    for (int i = 0; i < n; i++) begin
      if (!aborted) begin
        if (i == abort_at) begin
          do_reset(1 + $urandom_range(0, 1));
          aborted = 1;
        end else begin
          applyStimulus(1'b0, plan_mr[i], plan_op[i], plan_z[i], plan_exp[i], plan_tag[i]);
        end
      end
    end
    plan_mr.delete();
    plan_op.delete();
    plan_z.delete();
    plan_exp.delete();
    plan_tag.delete();
  endtask

  task automatic run_instr(input logic [3:0] op, input int fw, input int dw,
                           input logic z, input int abort_at);
    build_instr(op, fw, dw, z, 4);
    play(abort_at);
    if (op == 4'd10 || op == 4'd14 || op == 4'd15) do_reset(2);
  endtask

  initial begin
    logic [3:0] op;
    int         n_plan;
    int         abort_at;
    rst = 1'b1; mem_ready = 1'b0; Opcode = '0; zero = 1'b0;
    @(posedge clk);
    #1;
    do_reset(3);

    run_instr(4'b0010, 0, 0, 1'b0, -1);
    run_instr(4'b0000, 2, 1, 1'b0, -1);
    run_instr(4'b1011, 0, 0, 1'b1, -1);
    run_instr(4'b1011, 0, 0, 1'b0, -1);
    run_instr(4'b1100, 0, 0, 1'b0, -1);
    run_instr(4'b0001, 0, 1, 1'b0, -1);
    run_instr(4'b1101, 0, 0, 1'b0, -1);

    build_instr(4'b1110, 0, 0, 1'b0, 22);
    play(-1);
    do_reset(2);
    run_instr(4'b0101, 1, 0, 1'b0, -1);

    // Reset lands on the second MEM_RD wait cycle of a load.
    run_instr(4'b0000, 0, 3, 1'b0, 4);
    run_instr(4'b0011, 0, 0, 1'b0, -1);

    for (int k = 0; k < 200; k++) begin
      op = rop();
      if ((op == 4'd10 || op == 4'd14 || op == 4'd15) && $urandom_range(0, 3) != 0)
        op = 4'($urandom_range(0, 9));
      build_instr(op, $urandom_range(0, 2), $urandom_range(0, 2), rbit(),
                  $urandom_range(3, 6));
      n_plan = plan_mr.size();
      abort_at = ($urandom_range(0, 15) == 0) ? $urandom_range(0, n_plan - 1) : -1;
      play(abort_at);
      if (op == 4'd10 || op == 4'd14 || op == 4'd15) do_reset(2);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
